fpu_job_sequencer: RTL and testbench

- Upstream feeder for the 16-bit FPU core.
- Accepts complete jobs (operand A, operand B, 2-bit opcode) on a valid/ready interface and queues them in a small FIFO.
- Serialises each job onto the FPU's shared start/data load bus, then waits for the FPU's completion (ready) or error indication before issuing the next job.
- Reports per-job completion status upstream.

---
 rtl/fpu_pkg.sv | 30 +++
 rtl/fpu_job_fifo.sv | 64 ++++++
 rtl/fpu_job_sequencer.sv | 175 +++++++++++++++++
 tb/tb_fpu_job_sequencer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types and constants for the FPU job sequencer.
package fpu_pkg;

  localparam int unsigned EXP_W = 5;
  localparam int unsigned MAN_W = 10;
  localparam int unsigned FP_W  = 1 + EXP_W + MAN_W;
  localparam int unsigned OP_W  = 2;
  localparam int unsigned JOB_W = 2 * FP_W + OP_W;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_MUL = 2'b10;
  localparam logic [OP_W-1:0] OP_DIV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD_A  = 3'd1,
    ST_LOAD_B  = 3'd2,
    ST_LOAD_OP = 3'd3,
    ST_WAIT    = 3'd4
  } seq_state_e;

  // One queued job, JOB_W bits: {a, b, op}.
  typedef struct packed {
    logic [FP_W-1:0] a;
    logic [FP_W-1:0] b;
    logic [OP_W-1:0] op;
  } fpu_job_t;

endpackage

// File: rtl/fpu_job_fifo.sv
// Synchronous job FIFO; pointers carry one extra wrap bit to separate full from empty.
// Flags and level are registered; full is held high during reset so in_ready stays low.
module fpu_job_fifo
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fpu_job_t               wdata,
  input  logic                   pop,
  output fpu_job_t               rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  fpu_job_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr_n;
  logic [PW-1:0] rd_ptr_n;
  logic          do_push;
  logic          do_pop;

  // Qualified accesses and next pointer values.
  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_n = wr_ptr + PW'(do_push);
    rd_ptr_n = rd_ptr + PW'(do_pop);
  end

  // Pointer, flag and level registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b1;
      empty  <= 1'b1;
      level  <= '0;
    end else begin
      wr_ptr <= wr_ptr_n;
      rd_ptr <= rd_ptr_n;
      full   <= (wr_ptr_n[AW] != rd_ptr_n[AW]) && (wr_ptr_n[AW-1:0] == rd_ptr_n[AW-1:0]);
      empty  <= (wr_ptr_n == rd_ptr_n);
      level  <= wr_ptr_n - rd_ptr_n;
    end
  end

  // Storage array; contents need no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr[AW-1:0]] <= wdata;
    end
  end

  assign rdata = mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/fpu_job_sequencer.sv
// Queues FPU jobs and serialises each onto the FPU start/data load bus, then waits
// for completion. Optional watchdog in WAIT: define FPU_SEQ_WATCHDOG_EN.
// Bus outputs are registered from the next state, so each word lines up with its state.
module fpu_job_sequencer
  import fpu_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 16
`ifdef FPU_SEQ_WATCHDOG_EN
  ,
  parameter int unsigned TMO_CYC = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [FP_W-1:0]        in_a,
  input  logic [FP_W-1:0]        in_b,
  input  logic [OP_W-1:0]        in_op,
  output logic                   fpu_start,
  output logic [FP_W-1:0]        fpu_data,
  input  logic                   fpu_ready,
  input  logic                   fpu_error,
  output logic                   done,
  output logic                   done_err,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]       jobs_done
`ifdef FPU_SEQ_WATCHDOG_EN
  ,
  output logic                   timeout_seen
`endif
);

  localparam int unsigned LW = $clog2(DEPTH) + 1;

  seq_state_e      state;
  seq_state_e      state_n;
  fpu_job_t        head;
  logic            full;
  logic            empty;
  logic            push;
  logic            pop;
  logic [FP_W-1:0] job_b;
  logic [OP_W-1:0] job_op;
  logic            start_n;
  logic [FP_W-1:0] data_n;
  logic            done_n;
  logic            err_n;
  logic            busy_n;
  logic [LW-1:0]   level_after;

`ifdef FPU_SEQ_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TMO_CYC + 1);
  logic [WD_W-1:0] wd_cnt;
  logic            tmo;
`endif

  assign in_ready = ~full;
  assign push     = in_valid && in_ready;

  fpu_job_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .push (push),
    .wdata('{a: in_a, b: in_b, op: in_op}),
    .pop  (pop),
    .rdata(head),
    .full (full),
    .empty(empty),
    .level(fifo_level)
  );

  // Next state, pop request and next values of the registered outputs.
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    start_n = 1'b0;
    data_n  = '0;
    done_n  = 1'b0;
    err_n   = 1'b0;
`ifdef FPU_SEQ_WATCHDOG_EN
    tmo     = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          start_n = 1'b1;
          data_n  = head.a;
          state_n = ST_LOAD_A;
        end
      end
      ST_LOAD_A: begin
        data_n  = job_b;
        state_n = ST_LOAD_B;
      end
      ST_LOAD_B: begin
        data_n  = FP_W'(job_op);
        state_n = ST_LOAD_OP;
      end
      ST_LOAD_OP: begin
        state_n = ST_WAIT;
      end
      ST_WAIT: begin
        if (fpu_ready || fpu_error) begin
          done_n  = 1'b1;
          err_n   = fpu_error;
          state_n = ST_IDLE;
        end
`ifdef FPU_SEQ_WATCHDOG_EN
        else if (wd_cnt == WD_W'(TMO_CYC - 1)) begin
          done_n  = 1'b1;
          err_n   = 1'b1;
          tmo     = 1'b1;
          state_n = ST_IDLE;
        end
`endif
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
    level_after = fifo_level + LW'(push) - LW'(pop);
    busy_n      = (state_n != ST_IDLE) || (level_after != '0);
  end

  // State, output and job holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      fpu_start <= 1'b0;
      fpu_data  <= '0;
      done      <= 1'b0;
      done_err  <= 1'b0;
      busy      <= 1'b0;
      jobs_done <= '0;
      job_b     <= '0;
      job_op    <= '0;
    end else begin
      state     <= state_n;
      fpu_start <= start_n;
      fpu_data  <= data_n;
      done      <= done_n;
      done_err  <= err_n;
      busy      <= busy_n;
      if (done_n) begin
        jobs_done <= jobs_done + CNT_W'(1);
      end
      if (pop) begin
        job_b  <= head.b;
        job_op <= head.op;
      end
    end
  end

`ifdef FPU_SEQ_WATCHDOG_EN
  // WAIT cycle counter (zero on entry to WAIT) and sticky timeout flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_cnt       <= '0;
      timeout_seen <= 1'b0;
    end else begin
      wd_cnt <= (state == ST_WAIT) ? wd_cnt + WD_W'(1) : '0;
      if (tmo) begin
        timeout_seen <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fpu_job_sequencer.sv
// Scoreboard bench for fpu_job_sequencer: stimulus queues expected load words and
// completions; a monitor compares whenever the DUT drives the bus or pulses done.
// Watchdog checks are built when FPU_SEQ_WATCHDOG_EN is defined.
module tb_fpu_job_sequencer;
  import fpu_pkg::*;

  typedef struct packed {
    logic       err;
    logic [2:0] cnt;
  } done_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [1:0]  in_op = '0;
  logic        fpu_start;
  logic [15:0] fpu_data;
  logic        fpu_ready = 1'b0;
  logic        fpu_error = 1'b0;
  logic        done;
  logic        done_err;
  logic        busy;
  logic [2:0]  fifo_level;
  logic [2:0]  jobs_done;
`ifdef FPU_SEQ_WATCHDOG_EN
  logic        timeout_seen;
`endif

  logic [15:0] exp_load[$];
  done_t       exp_done[$];
  int          total = 0;
  int          bad = 0;
  int          njobs = 0;

  always #5 clk = ~clk;

  fpu_job_sequencer #(
    .DEPTH(4),
    .CNT_W(3)
`ifdef FPU_SEQ_WATCHDOG_EN
    ,
    .TMO_CYC(16)
`endif
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .fpu_start (fpu_start),
    .fpu_data  (fpu_data),
    .fpu_ready (fpu_ready),
    .fpu_error (fpu_error),
    .done      (done),
    .done_err  (done_err),
    .busy      (busy),
    .fifo_level(fifo_level),
    .jobs_done (jobs_done)
`ifdef FPU_SEQ_WATCHDOG_EN
    ,
    .timeout_seen(timeout_seen)
`endif
  );

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string nm);
    logic [26:0] v;
    v = {in_ready, fpu_start, fpu_data, done, done_err, busy, fifo_level, jobs_done};
    chk(v == '0, nm, 32'(v), 32'h0);
  endtask

  // Offer one job that the bench expects to be accepted.
  task automatic push_job(input logic [15:0] a, input logic [15:0] b, input logic [1:0] op);
    chk(in_ready == 1'b1, "push_in_ready", 32'(in_ready), 32'h1);
    exp_load.push_back(a);
    exp_load.push_back(b);
    exp_load.push_back(16'(op));
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_op    = op;
    tick();
    in_valid = 1'b0;
  endtask

  // Wait (bounded) until fpu_start is seen; n = cycles waited.
  task automatic wait_start(output int n);
    n = 0;
    while (!fpu_start && n < 40) begin
      tick();
      n++;
    end
    if (!fpu_start) chk(1'b0, "start_timeout", 32'(n), 32'd40);
  endtask

  // Pulse the FPU response after pre+dly cycles and queue the expected completion.
  task automatic respond(input int pre, input int dly, input bit rdy, input bit err);
    done_t e;
    repeat (pre) tick();
    repeat (dly) tick();
    fpu_ready = rdy;
    fpu_error = err;
    njobs++;
    e = {err, 3'(njobs)};
    exp_done.push_back(e);
    tick();
    fpu_ready = 1'b0;
    fpu_error = 1'b0;
  endtask

  task automatic monitor();
    int          ph;
    logic [15:0] w;
    done_t       e;
    ph = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ph = 0;
      end else begin
        if (fpu_start || ph != 0) begin
          if (fpu_start && ph != 0) chk(1'b0, "start_mid_load", 32'(ph), 32'h0);
          if (exp_load.size() == 0) begin
            chk(1'b0, "unexpected_load", 32'(fpu_data), 32'h0);
          end else begin
            w = exp_load.pop_front();
            chk(fpu_data == w, "load_word", 32'(fpu_data), 32'(w));
          end
          ph = (ph == 2) ? 0 : ph + 1;
        end else begin
          chk(fpu_data == 16'h0, "bus_idle", 32'(fpu_data), 32'h0);
        end
        if (done) begin
          if (exp_done.size() == 0) begin
            chk(1'b0, "unexpected_done", 32'({done_err, jobs_done}), 32'h0);
          end else begin
            e = exp_done.pop_front();
            chk({done_err, jobs_done} == e, "done_status", 32'({done_err, jobs_done}), 32'(e));
          end
        end else if (done_err) begin
          chk(1'b0, "err_without_done", 32'(done_err), 32'h0);
        end
      end
    end
  endtask

  task automatic stimulus();
    int n;
    int mlevel;
    int cnt;
    repeat (3) tick();
    chk_zero("reset_outputs");
    rst = 1'b0;
    tick();
    chk(in_ready == 1'b1, "in_ready_after_reset", 32'(in_ready), 32'h1);
    chk(fifo_level == 3'd0 && busy == 1'b0, "idle_after_reset", 32'({busy, fifo_level}), 32'h0);

    // Single job
    push_job(16'h3C00, 16'h4000, OP_ADD);
    chk(fifo_level == 3'd1, "level_after_push", 32'(fifo_level), 32'h1);
    chk(busy == 1'b1, "busy_after_push", 32'(busy), 32'h1);
    wait_start(n);
    chk(n == 1, "start_latency", 32'(n), 32'h1);
    chk(fifo_level == 3'd0, "level_after_pop", 32'(fifo_level), 32'h0);
    respond(3, 2, 1'b1, 1'b0);
    tick();
    chk(busy == 1'b0, "idle_after_job", 32'(busy), 32'h0);

    // Error path, then ready+error together
    push_job(16'h7C00, 16'h0000, OP_DIV);
    push_job(16'h3C00, 16'h3C00, OP_SUB);
    wait_start(n);
    respond(3, 1, 1'b0, 1'b1);
    wait_start(n);
    chk(n == 1, "next_job_after_error", 32'(n), 32'h1);
    respond(3, 0, 1'b1, 1'b1);

    // Stray completion during LOAD_B
    push_job(16'h4400, 16'h4200, OP_MUL);
    wait_start(n);
    tick();
    chk(fpu_data == 16'h4200, "in_load_b", 32'(fpu_data), 32'h4200);
    fpu_ready = 1'b1;
    tick();
    fpu_ready = 1'b0;
    tick();
    chk(fpu_data == 16'h0 && busy && !done, "wait_after_stray", 32'({done, busy, fpu_data}), 32'h10000);
    respond(0, 2, 1'b1, 1'b0);

    // Back-pressure: one job stalls in WAIT while five pushes are offered
    push_job(16'h4500, 16'h4600, OP_ADD);
    wait_start(n);
    repeat (3) tick();
    mlevel = 0;
    for (int i = 0; i < 5; i++) begin
      chk(in_ready == (mlevel < 4), "bp_in_ready", 32'(in_ready), 32'(mlevel < 4));
      if (mlevel < 4) begin
        exp_load.push_back(16'h5000 + 16'(i));
        exp_load.push_back(16'h5100 + 16'(i));
        exp_load.push_back(16'(i % 4));
        mlevel++;
      end
      in_valid = 1'b1;
      in_a     = 16'h5000 + 16'(i);
      in_b     = 16'h5100 + 16'(i);
      in_op    = 2'(i % 4);
      tick();
      chk(fifo_level == 3'(mlevel), "bp_level", 32'(fifo_level), 32'(mlevel));
    end
    in_valid = 1'b0;
    respond(0, 0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      wait_start(n);
      chk(n == 1, "bp_restart", 32'(n), 32'h1);
      respond(3, 0, 1'b1, 1'b0);
    end

    // Reset while in LOAD_B with two jobs queued
    push_job(16'h6000, 16'h6100, OP_ADD);
    push_job(16'h6200, 16'h6300, OP_SUB);
    push_job(16'h6400, 16'h6500, OP_MUL);
    chk(fifo_level == 3'd2 && fpu_data == 16'h6100, "pre_reset_state", 32'({fifo_level, fpu_data}), 32'h26100);
    rst = 1'b1;
    #1;
    chk_zero("reset_mid_job");
    exp_load.delete();
    tick();
    tick();
    rst = 1'b0;
    njobs = 0;
    tick();
    chk(in_ready == 1'b1 && fifo_level == 3'd0, "ready_after_mid_reset", 32'({in_ready, fifo_level}), 32'h8);
    repeat (8) tick();
    chk(busy == 1'b0 && jobs_done == 3'd0, "no_job_after_reset", 32'({busy, jobs_done}), 32'h0);

`ifdef FPU_SEQ_WATCHDOG_EN
    // Watchdog: never complete the first job
    chk(timeout_seen == 1'b0, "timeout_seen_clear", 32'(timeout_seen), 32'h0);
    push_job(16'h4800, 16'h4900, OP_ADD);
    push_job(16'h4A00, 16'h4B00, OP_SUB);
    wait_start(n);
    repeat (3) tick();
    njobs++;
    exp_done.push_back({1'b1, 3'(njobs)});
    cnt = 0;
    while (!done && cnt < 40) begin
      tick();
      cnt++;
    end
    chk(cnt == 16, "watchdog_cycles", 32'(cnt), 32'd16);
    chk(timeout_seen == 1'b1, "timeout_seen_set", 32'(timeout_seen), 32'h1);
    wait_start(n);
    chk(n == 1, "next_job_after_timeout", 32'(n), 32'h1);
    respond(3, 0, 1'b1, 1'b0);
    chk(timeout_seen == 1'b1, "timeout_seen_sticky", 32'(timeout_seen), 32'h1);
`else
    cnt = 0;
`endif

    repeat (4) tick();
    chk(exp_load.size() == 0 && exp_done.size() == 0, "scoreboard_drained",
        32'(exp_load.size() + exp_done.size()), 32'h0);
  endtask

  initial begin
    fork
      monitor();
      stimulus();
      begin
        repeat (5000) @(posedge clk);
        chk(1'b0, "global_timeout", 32'd5000, 32'h0);
      end
    join_any
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
